// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one RAM port between the icache and the dcache. The dcache wins
//   ordinary conflicts and keeps the RAM across both words of a two-word block
//   (lock). The icache is promoted once it has waited STARVE_LIMIT cycles, but
//   only at a block boundary. A watchdog abandons any access that stays in a
//   service state too long, or that the RAM reports as ERROR, and sets a
//   sticky err flag.
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   iREN, iaddr                   icache read request and word address
//   iwait, iload                  icache handshake (low for one cycle) and data
//   dREN, dWEN, daddr, dstore     dcache request, address and write data
//   dwait, dload                  dcache handshake (low for one cycle) and data
//   ramREN, ramWEN, ramaddr,
//   ramstore                      RAM command, decoded from the current state
//   ramload, ramstate             RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err                           sticky timeout/error flag
module cache_mem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_e;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic           lock_q, lock_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [WW-1:0]  wdog_q, wdog_d;
    logic           err_q, err_d;

    logic dreq, access, fault, icomp;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == RS_ACCESS);
    // Either the RAM reports a hard error or this is the last allowed cycle.
    assign fault  = (ramstate == RS_ERROR) || (wdog_q == WLAST);
    assign err    = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            lock_q   <= 1'b0;
            starve_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            starve_q <= starve_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        err_d    = err_q;
        icomp    = 1'b0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                // A held lock beats starvation so a block is never split.
                if (lock_q && dreq)                  state_d = DSERV;
                else if (iREN && starve_q >= SLIM)   state_d = ISERV;
                else if (dreq)                       state_d = DSERV;
                else if (iREN)                       state_d = ISERV;
            end
            DSERV: begin
                ramaddr  = daddr;
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramstore = dstore;
                if (dreq && access) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = IDLE;
                    // Finishing word0 of a block keeps the RAM for word1.
                    lock_d  = ~daddr[2];
                end else if (fault) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                end else if (!dreq) begin
                    state_d = IDLE;
                    lock_d  = 1'b0;
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (iREN && access) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    icomp   = 1'b1;
                    state_d = IDLE;
                end else if (fault) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                end else if (!iREN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog counts service cycles only.
        wdog_d = (state_q == IDLE) ? '0 : wdog_q + 1'b1;

        if (!iREN || icomp)
            starve_d = '0;
        else if (state_q != ISERV && starve_q < SLIM)
            starve_d = starve_q + 1'b1;
        else
            starve_d = starve_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. A small RAM model answers ACCESS after
// a programmable number of BUSY cycles (or stays BUSY when forced) and returns
// ramaddr ^ KEY as read data. A negedge monitor records completed RAM accesses.
module tb_cache_mem_arbiter;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2;

    logic        CLK, RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_chk, n_fail;
    int lat, cnt, force_busy;
    int ic_done, dc_done;
    logic [31:0] addr_q[$];

    cache_mem_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model
    assign ramload  = ramaddr ^ KEY;
    assign ramstate = !(ramREN | ramWEN) ? RS_FREE :
                      (force_busy != 0)  ? RS_BUSY :
                      (cnt >= lat)       ? RS_ACCESS : RS_BUSY;

    always @(posedge CLK) begin
        if ((ramREN | ramWEN) && ramstate != RS_ACCESS) cnt <= cnt + 1;
        else                                            cnt <= 0;
    end

    always @(negedge CLK) begin
        if (!iwait) ic_done++;
        if (!dwait) dc_done++;
        if ((ramREN | ramWEN) && ramstate == RS_ACCESS) addr_q.push_back(ramaddr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Behaves as both caches: advances daddr by one word per dcache completion,
    // drops iREN after the icache completes, raises iREN after i_delay edges.
    task automatic run_traffic(input int d_words, input logic [31:0] dbase,
                               input int i_delay, input logic [31:0] ia);
        int dn;
        bit idone, dw, iw;
        dn = 0; idone = 0;
        daddr = dbase; dREN = (d_words > 0); iaddr = ia;
        if (i_delay == 0) iREN = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            dw = dwait; iw = iwait;
            cyc();
            if (c + 1 == i_delay) iREN = 1'b1;
            if (!dw) begin
                dn++;
                if (dn == d_words) dREN = 1'b0;
                else daddr = daddr + 32'd4;
            end
            if (!iw) begin iREN = 1'b0; idone = 1; end
            if (dn == d_words && idone) break;
        end
        chk("traffic_done", 32'(dn == d_words && idone), 32'd1);
    endtask

    task automatic chk_seq(input string tag, input logic [31:0] exp[$]);
        chk({tag, "_len"}, 32'(addr_q.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < addr_q.size(); k++)
            chk(tag, addr_q[k], exp[k]);
    endtask

    initial begin
        int n, d0, i0;
        logic [31:0] exp[$];
        n_chk = 0; n_fail = 0; lat = 1; force_busy = 0; cnt = 0;
        ic_done = 0; dc_done = 0;
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;

        // Reset state
        @(negedge CLK);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        @(posedge CLK); #1 RST = 1'b0;
        cyc();

        // 1. Lone icache read, ACCESS in the second service cycle
        i0 = ic_done;
        lat = 1; iaddr = 32'h40; iREN = 1'b1;
        cyc();
        @(negedge CLK);
        chk("t1_ramREN", 32'(ramREN), 32'd1);
        chk("t1_ramaddr", ramaddr, 32'h40);
        chk("t1_iwait_busy", 32'(iwait), 32'd1);
        cyc();
        @(negedge CLK);
        chk("t1_iwait_done", 32'(iwait), 32'd0);
        chk("t1_iload", iload, 32'h40 ^ KEY);
        cyc(); iREN = 1'b0;
        repeat (3) cyc();
        chk("t1_once", 32'(ic_done - i0), 32'd1);

        // 2. Concurrent: both dcache words via lock, then icache
        lat = 0; addr_q.delete();
        run_traffic(2, 32'h100, 0, 32'h200);
        exp = '{32'h100, 32'h104, 32'h200};
        chk_seq("t2_seq", exp);
        repeat (2) cyc();

        // 3. Streaming dcache; icache promoted only at a block boundary
        addr_q.delete();
        run_traffic(8, 32'h1000, 1, 32'h300);
        exp = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014,
                32'h300, 32'h1018, 32'h101C};
        chk_seq("t3_seq", exp);
        repeat (2) cyc();

        // 4. dcache write
        d0 = dc_done; lat = 1;
        dWEN = 1'b1; daddr = 32'h3100; dstore = 32'hDEADBEEF;
        cyc();
        @(negedge CLK);
        chk("t4_ramWEN", 32'(ramWEN), 32'd1);
        chk("t4_ramREN", 32'(ramREN), 32'd0);
        chk("t4_ramaddr", ramaddr, 32'h3100);
        chk("t4_ramstore", ramstore, 32'hDEADBEEF);
        chk("t4_dwait_busy", 32'(dwait), 32'd1);
        cyc();
        @(negedge CLK);
        chk("t4_dwait_done", 32'(dwait), 32'd0);
        cyc(); dWEN = 1'b0;
        repeat (3) cyc();
        chk("t4_once", 32'(dc_done - d0), 32'd1);

        // 5. RAM stuck BUSY: watchdog after 64 service cycles
        d0 = dc_done; force_busy = 1;
        dREN = 1'b1; daddr = 32'h500;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (err) break;
            if (ramREN) n++;
        end
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_svc_cycles", 32'(n), 32'd64);
        chk("t5_released", 32'(ramREN), 32'd0);
        chk("t5_dwait", 32'(dwait), 32'd1);
        dREN = 1'b0; force_busy = 0;
        repeat (2) cyc();
        chk("t5_no_done", 32'(dc_done - d0), 32'd0);
        lat = 0; addr_q.delete();
        run_traffic(0, 32'h0, 0, 32'h60);
        exp = '{32'h60};
        chk_seq("t5_next", exp);
        repeat (2) cyc();

        // 6. Async reset mid-DSERV
        force_busy = 1; dREN = 1'b1; daddr = 32'h700;
        cyc();
        @(negedge CLK);
        chk("t6_pre_ramREN", 32'(ramREN), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("t6_ramREN", 32'(ramREN), 32'd0);
        chk("t6_ramWEN", 32'(ramWEN), 32'd0);
        chk("t6_dwait", 32'(dwait), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0; dREN = 1'b0; force_busy = 0;
        @(negedge CLK);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_idle_addr", ramaddr, 32'd0);
        chk("t6_idle_ren", 32'(ramREN), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
